uvmt_cv32e40s_rvfi_mem_collector: RTL and testbench

// - Producer side of the RVFI memory fields. Observes the core's OBI data bus and per-retirement pulses.
// - Packs all data transactions that completed for one instruction into one RVFI-style memory record:

---
 rtl/uvmt_cv32e40s_rvfi_mem_collector_pkg.sv | 33 +++
 rtl/uvmt_cv32e40s_rvfi_mem_collector_if.sv | 16 +
 rtl/uvmt_cv32e40s_rvfi_mem_txn_fifo.sv | 58 +++++
 rtl/uvmt_cv32e40s_rvfi_mem_collector.sv | 140 ++++++++++++++
 tb/tb_uvmt_cv32e40s_rvfi_mem_collector.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uvmt_cv32e40s_rvfi_mem_collector_pkg.sv
// Types and constants shared by the RVFI memory collector, its transaction FIFO and its interface users.
package uvmt_cv32e40s_rvfi_mem_pkg;

  localparam int NMEM_DEFAULT = 13;
  localparam int SLOT_IDX_W   = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_txn_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } mem_slot_t;

  // Reads carry only rmask/rdata, writes only wmask/wdata; the other side is forced to zero.
  function automatic mem_slot_t make_slot(input obi_txn_t txn, input logic [31:0] rdata);
    mem_slot_t s;
    s.addr  = txn.addr;
    s.rmask = txn.we ? 4'h0 : txn.be;
    s.wmask = txn.we ? txn.be : 4'h0;
    s.rdata = txn.we ? 32'h0 : rdata;
    s.wdata = txn.we ? txn.wdata : 32'h0;
    return s;
  endfunction

endpackage

// File: rtl/uvmt_cv32e40s_rvfi_mem_collector_if.sv
// OBI data-bus signal bundle observed by the RVFI memory collector.
interface uvmt_cv32e40s_rvfi_mem_collector_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master  (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
  modport slave   (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
  modport monitor (input req, gnt, addr, we, be, wdata, rvalid, rdata, err);
endinterface

// File: rtl/uvmt_cv32e40s_rvfi_mem_txn_fifo.sv
// Small FIFO of OBI A-phase transactions awaiting their R-phase; push and pop may share a cycle.
module uvmt_cv32e40s_rvfi_mem_txn_fifo
  import uvmt_cv32e40s_rvfi_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push,
  input  obi_txn_t push_data,
  input  logic     pop,
  output obi_txn_t head,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  obi_txn_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the entry a push into a full FIFO needs.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uvmt_cv32e40s_rvfi_mem_collector.sv
// Packs the OBI data transactions completed for each retired instruction into one RVFI-style record.
// Optional cover properties: define UVMT_RVFI_MEM_COLLECTOR_COV_EN.
module uvmt_cv32e40s_rvfi_mem_collector
  import uvmt_cv32e40s_rvfi_mem_pkg::*;
#(
  parameter int NMEM            = NMEM_DEFAULT,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  uvmt_cv32e40s_rvfi_mem_collector_if.monitor   obi,
  input  logic                                  retire_i,
  output logic                                  rec_valid_o,
  output logic [SLOT_IDX_W-1:0]                 rec_count_o,
  output logic [NMEM*32-1:0]                    rec_addr_o,
  output logic [NMEM*4-1:0]                     rec_rmask_o,
  output logic [NMEM*4-1:0]                     rec_wmask_o,
  output logic [NMEM*32-1:0]                    rec_rdata_o,
  output logic [NMEM*32-1:0]                    rec_wdata_o,
  output logic                                  rec_err_o,
  output logic                                  overflow_o
);

  localparam logic [SLOT_IDX_W-1:0] IDX_FULL = SLOT_IDX_W'(NMEM);

  obi_txn_t push_txn, head_txn;
  logic     push, pop, fifo_full, fifo_empty;
  logic     stray_rvalid, push_dropped, slot_dropped;

  mem_slot_t [NMEM-1:0]  slot_q, slot_nxt;
  logic [SLOT_IDX_W-1:0] idx_q, idx_nxt;
  logic                  err_q, err_nxt;

  logic [NMEM*32-1:0] rec_addr_d, rec_rdata_d, rec_wdata_d;
  logic [NMEM*4-1:0]  rec_rmask_d, rec_wmask_d;

  assign push     = obi.req && obi.gnt;
  assign push_txn = '{addr: obi.addr, we: obi.we, be: obi.be, wdata: obi.wdata};
  assign pop      = obi.rvalid && !fifo_empty;

  assign stray_rvalid = obi.rvalid && fifo_empty;
  assign push_dropped = push && fifo_full && !pop;
  assign slot_dropped = pop && (idx_q == IDX_FULL);

  uvmt_cv32e40s_rvfi_mem_txn_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_txn_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (push),
    .push_data (push_txn),
    .pop       (obi.rvalid),
    .head      (head_txn),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Accumulator view including this cycle's response, so a same-cycle R-phase joins the record.
  always_comb begin
    slot_nxt = slot_q;
    idx_nxt  = idx_q;
    err_nxt  = err_q;
    if (pop && !slot_dropped) begin
      slot_nxt[idx_q] = make_slot(head_txn, obi.rdata);
      idx_nxt         = idx_q + SLOT_IDX_W'(1);
      err_nxt         = err_q | obi.err;
    end
  end

  always_comb begin
    rec_addr_d  = '0;
    rec_rmask_d = '0;
    rec_wmask_d = '0;
    rec_rdata_d = '0;
    rec_wdata_d = '0;
    for (int i = 0; i < NMEM; i++) begin
      rec_addr_d[i*32 +: 32]  = slot_nxt[i].addr;
      rec_rmask_d[i*4 +: 4]   = slot_nxt[i].rmask;
      rec_wmask_d[i*4 +: 4]   = slot_nxt[i].wmask;
      rec_rdata_d[i*32 +: 32] = slot_nxt[i].rdata;
      rec_wdata_d[i*32 +: 32] = slot_nxt[i].wdata;
    end
  end

  // Slots are zeroed on every retire, so slots beyond the count always read 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q      <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      overflow_o  <= 1'b0;
      rec_valid_o <= 1'b0;
      rec_count_o <= '0;
      rec_addr_o  <= '0;
      rec_rmask_o <= '0;
      rec_wmask_o <= '0;
      rec_rdata_o <= '0;
      rec_wdata_o <= '0;
      rec_err_o   <= 1'b0;
    end else begin
      rec_valid_o <= retire_i;
      if (stray_rvalid || push_dropped || slot_dropped) begin
        overflow_o <= 1'b1;
      end
      if (retire_i) begin
        rec_count_o <= idx_nxt;
        rec_addr_o  <= rec_addr_d;
        rec_rmask_o <= rec_rmask_d;
        rec_wmask_o <= rec_wmask_d;
        rec_rdata_o <= rec_rdata_d;
        rec_wdata_o <= rec_wdata_d;
        rec_err_o   <= err_nxt;
        slot_q      <= '0;
        idx_q       <= '0;
        err_q       <= 1'b0;
      end else begin
        slot_q <= slot_nxt;
        idx_q  <= idx_nxt;
        err_q  <= err_nxt;
      end
    end
  end

`ifdef UVMT_RVFI_MEM_COLLECTOR_COV_EN
  cov_rec_count_2: cover property (@(posedge clk_i) disable iff (!rst_ni)
    rec_valid_o && (rec_count_o == SLOT_IDX_W'(2)));
  cov_rec_count_ge4: cover property (@(posedge clk_i) disable iff (!rst_ni)
    rec_valid_o && (rec_count_o >= SLOT_IDX_W'(4)));
  cov_rec_err: cover property (@(posedge clk_i) disable iff (!rst_ni)
    rec_valid_o && rec_err_o);
  // Something is still outstanding after this cycle's pop when the record closes.
  cov_rollover: cover property (@(posedge clk_i) disable iff (!rst_ni)
    retire_i && !fifo_empty && (!pop || fifo_full));
  cov_fifo_full: cover property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_full);
`else
  // Coverage points are left out of this build; the datapath is unchanged.
`endif

endmodule

// File: tb/tb_uvmt_cv32e40s_rvfi_mem_collector.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random traffic vs a queue model.
module tb_uvmt_cv32e40s_rvfi_mem_collector;

  localparam int NMEM = 13;
  localparam int MAXO = 2;
  localparam int W    = NMEM * 32;
  typedef logic [W-1:0] wide_t;

  logic clk, rst_n, retire;
  logic rec_valid, rec_err, overflow;
  logic [3:0] rec_count;
  logic [NMEM*32-1:0] rec_addr, rec_rdata, rec_wdata;
  logic [NMEM*4-1:0]  rec_rmask, rec_wmask;

  uvmt_cv32e40s_rvfi_mem_collector_if obi_if ();

  uvmt_cv32e40s_rvfi_mem_collector #(.NMEM(NMEM), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .obi         (obi_if),
    .retire_i    (retire),
    .rec_valid_o (rec_valid),
    .rec_count_o (rec_count),
    .rec_addr_o  (rec_addr),
    .rec_rmask_o (rec_rmask),
    .rec_wmask_o (rec_wmask),
    .rec_rdata_o (rec_rdata),
    .rec_wdata_o (rec_wdata),
    .rec_err_o   (rec_err),
    .overflow_o  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: outstanding transactions and the open record as plain queues.
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } ttxn_t;
  typedef struct { logic [31:0] addr; logic [3:0] rmask, wmask; logic [31:0] rdata, wdata; } tslot_t;

  ttxn_t  m_out[$];
  tslot_t m_acc[$];
  logic   m_err, m_valid, m_rerr, m_ovf;
  logic [3:0] m_count;
  logic [NMEM*32-1:0] m_addr, m_rdata, m_wdata;
  logic [NMEM*4-1:0]  m_rmask, m_wmask;

  task automatic model_reset();
    m_out.delete(); m_acc.delete();
    m_err = 1'b0; m_valid = 1'b0; m_rerr = 1'b0; m_ovf = 1'b0; m_count = '0;
    m_addr = '0; m_rdata = '0; m_wdata = '0; m_rmask = '0; m_wmask = '0;
  endtask

  task automatic model_step(input logic req, input logic gnt, input logic [31:0] addr, input logic we,
                            input logic [3:0] be, input logic [31:0] wdata, input logic rv,
                            input logic [31:0] rdata, input logic err, input logic ret);
    ttxn_t t;
    tslot_t s;
    m_valid = ret;
    if (rv) begin
      if (m_out.size() == 0) m_ovf = 1'b1;
      else begin
        t = m_out.pop_front();
        if (m_acc.size() >= NMEM) m_ovf = 1'b1;
        else begin
          s.addr  = t.addr;
          s.rmask = t.we ? 4'h0 : t.be;
          s.wmask = t.we ? t.be : 4'h0;
          s.rdata = t.we ? 32'h0 : rdata;
          s.wdata = t.we ? t.wdata : 32'h0;
          m_acc.push_back(s);
          m_err = m_err | err;
        end
      end
    end
    if (req && gnt) begin
      if (m_out.size() >= MAXO) m_ovf = 1'b1;
      else begin
        t.addr = addr; t.we = we; t.be = be; t.wdata = wdata;
        m_out.push_back(t);
      end
    end
    if (ret) begin
      m_count = 4'(m_acc.size());
      m_rerr  = m_err;
      m_addr = '0; m_rdata = '0; m_wdata = '0; m_rmask = '0; m_wmask = '0;
      foreach (m_acc[i]) begin
        m_addr[i*32 +: 32]  = m_acc[i].addr;
        m_rmask[i*4 +: 4]   = m_acc[i].rmask;
        m_wmask[i*4 +: 4]   = m_acc[i].wmask;
        m_rdata[i*32 +: 32] = m_acc[i].rdata;
        m_wdata[i*32 +: 32] = m_acc[i].wdata;
      end
      m_acc.delete();
      m_err = 1'b0;
    end
  endtask

  task automatic chk(input string name, input wide_t act, input wide_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " valid"},    wide_t'(rec_valid), wide_t'(m_valid));
    chk({tag, " count"},    wide_t'(rec_count), wide_t'(m_count));
    chk({tag, " addr"},     wide_t'(rec_addr),  wide_t'(m_addr));
    chk({tag, " rmask"},    wide_t'(rec_rmask), wide_t'(m_rmask));
    chk({tag, " wmask"},    wide_t'(rec_wmask), wide_t'(m_wmask));
    chk({tag, " rdata"},    wide_t'(rec_rdata), wide_t'(m_rdata));
    chk({tag, " wdata"},    wide_t'(rec_wdata), wide_t'(m_wdata));
    chk({tag, " err"},      wide_t'(rec_err),   wide_t'(m_rerr));
    chk({tag, " overflow"}, wide_t'(overflow),  wide_t'(m_ovf));
  endtask

  task automatic idle();
    obi_if.req = 1'b0; obi_if.gnt = 1'b0; obi_if.addr = '0; obi_if.we = 1'b0; obi_if.be = '0;
    obi_if.wdata = '0; obi_if.rvalid = 1'b0; obi_if.rdata = '0; obi_if.err = 1'b0; retire = 1'b0;
  endtask

  // Called at a negedge: drive, advance the model, clock once, check at the next negedge.
  task automatic cycle(input logic req, input logic gnt, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wdata, input logic rv,
                       input logic [31:0] rdata, input logic err, input logic ret);
    obi_if.req = req; obi_if.gnt = gnt; obi_if.addr = addr; obi_if.we = we; obi_if.be = be;
    obi_if.wdata = wdata; obi_if.rvalid = rv; obi_if.rdata = rdata; obi_if.err = err; retire = ret;
    model_step(req, gnt, addr, we, be, wdata, rv, rdata, err, ret);
    @(posedge clk);
    @(negedge clk);
    check_all("model");
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic a; logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;
    logic rv; logic [31:0] rdata; logic err; logic ret;
    logic chk; logic e_valid; logic [3:0] e_count; logic e_err;
    logic [31:0] e_addr0; logic [3:0] e_rm0, e_wm0, e_wm1; logic [31:0] e_rd0;
  } vec_t;

  function automatic vec_t st(input logic a, input logic [31:0] addr, input logic we, input logic [3:0] be,
                              input logic [31:0] wdata, input logic rv, input logic [31:0] rdata,
                              input logic err, input logic ret);
    vec_t v = '0;
    v.a = a; v.addr = addr; v.we = we; v.be = be; v.wdata = wdata;
    v.rv = rv; v.rdata = rdata; v.err = err; v.ret = ret;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t base, input logic valid, input logic [3:0] cnt, input logic err,
                              input logic [31:0] addr0, input logic [3:0] rm0, input logic [3:0] wm0,
                              input logic [3:0] wm1, input logic [31:0] rd0);
    vec_t v = base;
    v.chk = 1'b1; v.e_valid = valid; v.e_count = cnt; v.e_err = err;
    v.e_addr0 = addr0; v.e_rm0 = rm0; v.e_wm0 = wm0; v.e_wm1 = wm1; v.e_rd0 = rd0;
    return v;
  endfunction

  localparam int NVEC = 19;
  vec_t vecs[NVEC];
  vec_t v;
  logic rq, gn, rv, er, rt;

  initial begin
    // lw aligned
    vecs[0]  = st(1'b1, 32'h1000, 1'b0, 4'hF, '0, 1'b0, '0, 1'b0, 1'b0);
    vecs[1]  = st(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    vecs[2]  = ex(st(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1), 1'b1, 4'd1, 1'b0, 32'h1000, 4'hF, 4'h0, 4'h0, 32'hDEADBEEF);
    vecs[3]  = ex(st(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0), 1'b0, 4'd1, 1'b0, 32'h1000, 4'hF, 4'h0, 4'h0, 32'hDEADBEEF);
    // misaligned sw split into two words; write responses carry junk rdata
    vecs[4]  = st(1'b1, 32'h1000, 1'b1, 4'hC, 32'h11223344, 1'b0, '0, 1'b0, 1'b0);
    vecs[5]  = st(1'b1, 32'h1004, 1'b1, 4'h3, 32'h55667788, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    vecs[6]  = st(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    vecs[7]  = ex(st(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1), 1'b1, 4'd2, 1'b0, 32'h1000, 4'h0, 4'hC, 4'h3, 32'h0);
    // FIFO full, retire on first response, second rolls into next record
    vecs[8]  = st(1'b1, 32'h2000, 1'b0, 4'hF, '0, 1'b0, '0, 1'b0, 1'b0);
    vecs[9]  = st(1'b1, 32'h2004, 1'b0, 4'hF, '0, 1'b0, '0, 1'b0, 1'b0);
    vecs[10] = ex(st(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1), 1'b1, 4'd1, 1'b0, 32'h2000, 4'hF, 4'h0, 4'h0, 32'hA5A5A5A5);
    vecs[11] = ex(st(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b0), 1'b0, 4'd1, 1'b0, 32'h2000, 4'hF, 4'h0, 4'h0, 32'hA5A5A5A5);
    vecs[12] = ex(st(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1), 1'b1, 4'd1, 1'b0, 32'h2004, 4'hF, 4'h0, 4'h0, 32'h5A5A5A5A);
    // bus error, then empty record back-to-back, then clean record
    vecs[13] = st(1'b1, 32'h3000, 1'b0, 4'hF, '0, 1'b0, '0, 1'b0, 1'b0);
    vecs[14] = st(1'b0, '0, 1'b0, '0, '0, 1'b1, '0, 1'b1, 1'b0);
    vecs[15] = ex(st(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1), 1'b1, 4'd1, 1'b1, 32'h3000, 4'hF, 4'h0, 4'h0, 32'h0);
    vecs[16] = ex(st(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1), 1'b1, 4'd0, 1'b0, 32'h0, 4'h0, 4'h0, 4'h0, 32'h0);
    vecs[17] = st(1'b1, 32'h3004, 1'b0, 4'h1, '0, 1'b0, '0, 1'b0, 1'b0);
    vecs[18] = ex(st(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'h000000AB, 1'b0, 1'b1), 1'b1, 4'd1, 1'b0, 32'h3004, 4'h1, 4'h0, 4'h0, 32'h000000AB);

    rst_n = 1'b1;
    idle();
    model_reset();
    do_reset();

    for (int k = 0; k < NVEC; k++) begin
      v = vecs[k];
      cycle(v.a, v.a, v.addr, v.we, v.be, v.wdata, v.rv, v.rdata, v.err, v.ret);
      if (v.chk) begin
        chk($sformatf("vec%0d valid", k),  wide_t'(rec_valid),       wide_t'(v.e_valid));
        chk($sformatf("vec%0d count", k),  wide_t'(rec_count),       wide_t'(v.e_count));
        chk($sformatf("vec%0d err", k),    wide_t'(rec_err),         wide_t'(v.e_err));
        chk($sformatf("vec%0d ovf", k),    wide_t'(overflow),        wide_t'(1'b0));
        chk($sformatf("vec%0d addr0", k),  wide_t'(rec_addr[31:0]),  wide_t'(v.e_addr0));
        chk($sformatf("vec%0d rmask0", k), wide_t'(rec_rmask[3:0]),  wide_t'(v.e_rm0));
        chk($sformatf("vec%0d wmask0", k), wide_t'(rec_wmask[3:0]),  wide_t'(v.e_wm0));
        chk($sformatf("vec%0d wmask1", k), wide_t'(rec_wmask[7:4]),  wide_t'(v.e_wm1));
        chk($sformatf("vec%0d rdata0", k), wide_t'(rec_rdata[31:0]), wide_t'(v.e_rd0));
      end
    end

    // 14 write words in one record: the 14th is dropped and overflow sticks
    for (int i = 0; i < 14; i++)
      cycle(1'b1, 1'b1, 32'h4000 + 4*i, 1'b1, 4'hF, 32'(i), (i > 0), '0, 1'b0, 1'b0);
    chk("ovf_after_13_slots", wide_t'(overflow), wide_t'(1'b0));
    cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, '0, 1'b0, 1'b0);
    chk("ovf_after_14_slots", wide_t'(overflow), wide_t'(1'b1));
    cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("full_count", wide_t'(rec_count), wide_t'(4'd13));
    chk("slot12_addr", wide_t'(rec_addr[12*32 +: 32]), wide_t'(32'h4030));
    chk("slot12_wdata", wide_t'(rec_wdata[12*32 +: 32]), wide_t'(32'd12));
    repeat (3) cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    chk("ovf_sticky", wide_t'(overflow), wide_t'(1'b1));

    // reset with one transaction outstanding, then a stray response
    cycle(1'b1, 1'b1, 32'h5000, 1'b0, 4'hF, '0, 1'b0, '0, 1'b0, 1'b0);
    do_reset();
    chk("post_reset_ovf", wide_t'(overflow), wide_t'(1'b0));
    cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 32'h1234, 1'b0, 1'b0);
    chk("stray_rvalid_ovf", wide_t'(overflow), wide_t'(1'b1));
    chk("stray_rvalid_valid", wide_t'(rec_valid), wide_t'(1'b0));
    do_reset();

    // third push into a full FIFO without a pop is dropped
    cycle(1'b1, 1'b1, 32'h6000, 1'b0, 4'hF, '0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h6004, 1'b0, 4'hF, '0, 1'b0, '0, 1'b0, 1'b0);
    chk("full_no_drop_ovf", wide_t'(overflow), wide_t'(1'b0));
    cycle(1'b1, 1'b1, 32'h6008, 1'b0, 4'hF, '0, 1'b0, '0, 1'b0, 1'b0);
    chk("push_full_ovf", wide_t'(overflow), wide_t'(1'b1));
    cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 32'h11, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 32'h22, 1'b0, 1'b1);
    chk("push_full_count", wide_t'(rec_count), wide_t'(4'd2));
    chk("push_full_addr1", wide_t'(rec_addr[63:32]), wide_t'(32'h6004));
    do_reset();

    // random traffic, mostly protocol-legal, periodic resets clear the sticky flag
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) do_reset();
      gn = ($urandom_range(0, 3) != 0);
      rq = (m_out.size() < MAXO) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      rv = (m_out.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
      er = ($urandom_range(0, 9) == 0);
      rt = ($urandom_range(0, 4) == 0);
      cycle(rq, gn, $urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, rv, $urandom, er, rt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
